// File: rtl/instrumented_adder_pkg.sv
// Shared types and constants for the instrumented adder measurement controller.
package instrumented_adder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int SYNC_STAGES  = 2;
  // One extra cycle lets the edge-detect flop see the last synchronised edge.
  localparam int DRAIN_CYCLES = SYNC_STAGES + 1;

endpackage

// File: rtl/instrumented_adder_ctrl_ring_edge_counter.sv
// Synchronises the asynchronous ring tap, detects rising edges and counts them
// into a saturating counter with a sticky overflow flag.
module ring_edge_counter
  import instrumented_adder_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             ring_in,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_rise;

  // Synchroniser and edge-detect run continuously so the pipeline is primed
  // before counting is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ring_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (enable && w_rise) begin
      if (&count) begin
        overflow <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instrumented_adder_ctrl.sv
// Measurement controller: loads adder operands, opens the ring-oscillator loop
// for a programmed window, counts ring edges and captures the adder sum.
module instrumented_adder_ctrl
  import instrumented_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 32,
  parameter int SETTLE = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] window,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             ring_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             ring_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ring_count,
  output logic [WIDTH-1:0] sum_capture,
  output logic             overflow
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_window;
  logic [CNT_W-1:0] w_run_len;
  logic             w_idle_or_done;
  logic             w_accept;
  logic             w_cnt_zero;
  logic             w_count_en;

  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept       = start && !abort && w_idle_or_done;
  assign w_cnt_zero     = (r_cnt == '0);
  // A zero window still opens the loop for a single cycle.
  assign w_run_len      = (r_window == '0) ? '0 : r_window - 1'b1;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start) w_state_next = S_SETTLE;
        S_SETTLE: if (w_cnt_zero) w_state_next = S_RUN;
        S_RUN:    if (w_cnt_zero) w_state_next = S_DRAIN;
        S_DRAIN:  if (w_cnt_zero) w_state_next = S_DONE;
        S_DONE:   if (start) w_state_next = S_SETTLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // Phase counter is reloaded on every state change, so each phase counts down to 0.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      a_out       <= '0;
      b_out       <= '0;
      r_window    <= '0;
      r_cnt       <= '0;
      sum_capture <= '0;
    end else if (w_accept) begin
      a_out    <= a_in;
      b_out    <= b_in;
      r_window <= window;
      r_cnt    <= CNT_W'(SETTLE - 1);
    end else begin
      case (r_state)
        S_SETTLE: r_cnt <= w_cnt_zero ? w_run_len : r_cnt - 1'b1;
        S_RUN:    r_cnt <= w_cnt_zero ? CNT_W'(DRAIN_CYCLES - 1) : r_cnt - 1'b1;
        S_DRAIN: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!abort) begin
            sum_capture <= sum_in;
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign ring_en    = (r_state == S_RUN);
  assign busy       = (r_state == S_SETTLE) || (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign w_count_en = (r_state == S_RUN) || (r_state == S_DRAIN);

  ring_edge_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n),
    .clear    (w_accept),
    .enable   (w_count_en),
    .ring_in  (ring_in),
    .count    (ring_count),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_instrumented_adder_ctrl.sv
// Directed bench for instrumented_adder_ctrl plus a narrow ring_edge_counter for saturation.
module tb_instrumented_adder_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 32;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_n;
  logic             start, abort;
  logic [CNT_W-1:0] window;
  logic [WIDTH-1:0] a_in, b_in, sum_in;
  logic             ring_in = 1'b0;
  logic             ring_on = 1'b0;
  logic [WIDTH-1:0] a_out, b_out, sum_capture;
  logic             ring_en, busy, done, overflow;
  logic [CNT_W-1:0] ring_count;

  logic       sat_clr, sat_en, sat_ring;
  logic [3:0] sat_cnt;
  logic       sat_ov;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 wb_clk_i = ~wb_clk_i;
  // Ring half-period 40 ns = 4 clocks; toggles never coincide with a clock edge.
  always #40 if (ring_on) ring_in = ~ring_in;

  assign sum_in = a_out + b_out;

  instrumented_adder_ctrl #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .SETTLE(4)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n   (wb_rst_n),
    .start      (start),
    .abort      (abort),
    .window     (window),
    .a_in       (a_in),
    .b_in       (b_in),
    .sum_in     (sum_in),
    .ring_in    (ring_in),
    .a_out      (a_out),
    .b_out      (b_out),
    .ring_en    (ring_en),
    .busy       (busy),
    .done       (done),
    .ring_count (ring_count),
    .sum_capture(sum_capture),
    .overflow   (overflow)
  );

  ring_edge_counter #(.CNT_W(4)) u_sat (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n),
    .clear   (sat_clr),
    .enable  (sat_en),
    .ring_in (sat_ring),
    .count   (sat_cnt),
    .overflow(sat_ov)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic start_meas(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [CNT_W-1:0] w);
    a_in = a; b_in = b; window = w; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int en_cyc, output int st_cyc);
    bit ok;
    ok = 1'b0; en_cyc = 0; st_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (ring_en) en_cyc++;
      else if (busy && en_cyc == 0) st_cyc++;
      tick();
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_ring_en(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ring_en) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("ring_en_timeout", 0, 1);
  endtask

  task automatic sat_edges(input int n);
    for (int i = 0; i < n; i++) begin
      sat_ring = 1'b1; tick(); tick();
      sat_ring = 1'b0; tick(); tick();
    end
    repeat (3) tick();
  endtask

  int en, st;
  logic [CNT_W-1:0] rc;

  initial begin
    wb_rst_n = 1'b0; start = 1'b0; abort = 1'b0; window = '0; a_in = '0; b_in = '0;
    sat_clr = 1'b0; sat_en = 1'b0; sat_ring = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ring_en", ring_en, 0);
    chk("rst_count", ring_count, 0);
    chk("rst_a_out", a_out, 0);
    wb_rst_n = 1'b1;
    tick();
    ring_on = 1'b1;

    // Basic measurement
    start_meas(5, 7, 100);
    run_until_done(300, en, st);
    chk("basic_en_cycles", en, 100);
    chk("basic_settle_cycles", st, 4);
    chk("basic_done", done, 1);
    chk("basic_busy", busy, 0);
    chk("basic_sum", sum_capture, 12);
    chk("basic_a_out", a_out, 5);
    chk("basic_b_out", b_out, 7);
    chk("basic_count_12_13", (ring_count == 12 || ring_count == 13), 1);
    chk("basic_overflow", overflow, 0);
    repeat (20) tick();
    chk("done_hold_count", (ring_count == 12 || ring_count == 13), 1);
    chk("done_hold_done", done, 1);

    // Zero window behaves as one cycle
    start_meas(1, 1, 0);
    chk("w0_busy", busy, 1);
    chk("w0_done_cleared", done, 0);
    run_until_done(50, en, st);
    chk("w0_en_cycles", en, 1);
    chk("w0_done", done, 1);
    chk("w0_count_le1", (ring_count <= 1), 1);
    chk("w0_sum", sum_capture, 2);

    // Start while busy is ignored
    start_meas(5, 7, 20);
    a_in = 9; b_in = 9; window = 3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_a_out", a_out, 5);
    run_until_done(100, en, st);
    chk("busy_start_en_cycles", en, 20);
    chk("busy_start_sum", sum_capture, 12);

    // Start and abort together from DONE
    a_in = 3; b_in = 3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_done", done, 0);
    chk("sa_a_out", a_out, 5);
    repeat (3) tick();
    chk("sa_still_idle", busy, 0);

    // Abort at RUN cycle 50
    start_meas(2, 2, 1000);
    wait_ring_en(20);
    repeat (49) tick();
    chk("abort_pre_en", ring_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ring_en", ring_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_partial", (ring_count >= 5 && ring_count <= 8), 1);
    repeat (80) tick();
    chk("abort_hold", (ring_count >= 5 && ring_count <= 8), 1);
    chk("abort_a_out", a_out, 2);
    start_meas(1, 2, 10);
    run_until_done(100, en, st);
    chk("post_abort_en", en, 10);
    chk("post_abort_sum", sum_capture, 3);
    chk("post_abort_done", done, 1);

    // Saturation on a 4-bit counter
    sat_en = 1'b1;
    sat_edges(5);
    chk("sat_count5", sat_cnt, 5);
    chk("sat_ov0", sat_ov, 0);
    sat_en = 1'b0;
    sat_edges(3);
    chk("sat_disabled", sat_cnt, 5);
    sat_en = 1'b1;
    sat_edges(40);
    chk("sat_count15", sat_cnt, 15);
    chk("sat_ov1", sat_ov, 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_clr_count", sat_cnt, 0);
    chk("sat_clr_ov", sat_ov, 0);

    // Asynchronous reset mid-RUN
    start_meas(5, 7, 1000);
    wait_ring_en(20);
    repeat (20) tick();
    chk("prerst_en", ring_en, 1);
    #2 wb_rst_n = 1'b0;
    #1;
    chk("arst_ring_en", ring_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", ring_count, 0);
    chk("arst_a_out", a_out, 0);
    chk("arst_sum", sum_capture, 0);
    chk("arst_overflow", overflow, 0);
    tick();
    wb_rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instrumented_adder_ctrl.md
Name: instrumented_adder_ctrl

Overview:
- Measurement controller sitting directly upstream of the instrumented adder.
- Loads the A/B operands, enables the adder's ring-oscillator loop for a programmed window of wb_clk_i cycles and counts the ring's rising edges.
- Captures the adder sum and reports count, done and overflow back to the logic-analyser (LA) register side.
- All control is single-clock. The ring signal is treated as asynchronous and is synchronised inside this block.

Parameters:
- WIDTH, 32, operand/sum width driven to and read from the adder
- CNT_W, 32, ring edge counter and window counter width
- SETTLE, 4, wb_clk_i cycles operands are held stable before ring_en asserts (range 1..15)

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a measurement when idle
- abort  in  1  single-cycle pulse; cancels a measurement in progress
- window  in  CNT_W  number of wb_clk_i cycles ring_en stays high; sampled at start
- a_in  in  WIDTH  operand A; sampled at start
- b_in  in  WIDTH  operand B; sampled at start
- sum_in  in  WIDTH  adder sum output
- ring_in  in  1  adder chain_out / ring tap; asynchronous
- a_out  out  WIDTH  registered operand A to the adder
- b_out  out  WIDTH  registered operand B to the adder
- ring_en  out  1  closes the ring loop
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE; cleared by the next start
- ring_count  out  CNT_W  rising edges counted in the last window
- sum_capture  out  WIDTH  sum_in sampled on entry to DONE
- overflow  out  1  ring_count saturated in the last window

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - All outputs 0.
  - FSM = IDLE.
  - Synchroniser flops = 0.
- States:
  - IDLE -> SETTLE on start.
  - SETTLE -> RUN after SETTLE cycles.
  - RUN -> DRAIN when the window counter reaches 0.
  - DRAIN -> DONE after 3 cycles.
  - DONE -> SETTLE on start.
- start in IDLE or DONE:
  - Latch a_in/b_in into a_out/b_out and latch window.
  - Clear ring_count, overflow and done.
  - busy=1 from the next cycle.
- start while busy: ignored.
- SETTLE: ring_en=0; counts SETTLE cycles.
- RUN:
  - ring_en=1 for exactly window cycles.
  - window=0 is treated as 1.
- Synchronisation and counting:
  - ring_in passes through a 2-flop synchroniser, then an edge-detect flop.
  - Each synchronised 0->1 transition increments ring_count.
  - Edge counting is enabled in RUN and DRAIN, so edges in the synchroniser pipeline at window end are still counted.
  - Ring frequencies above wb_clk_i/2 alias; this is documented and not detected.
- Saturation: ring_count saturates at all-ones and sets overflow (sticky until the next start).
- DRAIN:
  - ring_en=0; 3 cycles (synchroniser depth + 1).
  - On the last cycle, sum_capture <= sum_in.
- DONE: busy=0, done=1; ring_count and sum_capture held stable.
- abort while busy:
  - Next cycle: ring_en=0, FSM=IDLE, busy=0, done=0.
  - ring_count keeps its partial value; overflow keeps its value.
- Simultaneous events:
  - start and abort in the same cycle from IDLE/DONE: abort wins, nothing starts.
  - Window expiry and abort in the same cycle: abort wins.
- Reset mid-measurement: immediate clear, ring_en drops asynchronously.
- a_out/b_out change only on an accepted start.

Decomposition:
- Shared package instrumented_adder_pkg:
  - state enum (IDLE, SETTLE, RUN, DRAIN, DONE)
  - SYNC_STAGES=2
  - DRAIN_CYCLES=SYNC_STAGES+1
- Sub-module ring_edge_counter: synchroniser, edge detect, saturating counter, overflow flag. Ports: clk, rst_n, clear, enable, ring_in, count, overflow.

Test Plan:
- Reset: assert wb_rst_n=0 mid-RUN with ring toggling -> all outputs 0 immediately; busy=0, ring_en=0.
- Basic measurement: a_in=5, b_in=7, window=100, ring_in toggles every 4 clk (period 8) -> ring_en high exactly 100 cycles after 4 settle cycles; done asserts; ring_count=12 or 13; sum_capture=12.
- window=0: start -> ring_en high exactly 1 cycle; done asserts after DRAIN; ring_count<=1.
- Saturation: CNT_W=4, window=200, ring period 4 clk -> ring_count=15, overflow=1; next start clears both.
- Abort: start with window=1000, abort at cycle 50 of RUN -> ring_en=0 next cycle; busy=0, done=0; ring_count equals edges counted so far; a later start runs normally.
- start while busy, and start+abort together from DONE -> second start ignored (a_out unchanged); combined pulse leaves FSM in IDLE with done=0.
